// File: rtl/rf_write_arbiter.sv
// Two-requester write-port arbiter for the 8x8 register file.
// Optional pending-register mask built when RFARB_PENDING_EN is defined.
module rf_write_arbiter #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0Valid,
    output logic                req0Ready,
    input  logic [ADDR_W-1:0]   req0Reg,
    input  logic [DATA_W-1:0]   req0Data,
    input  logic                req1Valid,
    output logic                req1Ready,
    input  logic [ADDR_W-1:0]   req1Reg,
    input  logic [DATA_W-1:0]   req1Data,
    output logic                regWrite,
    output logic [ADDR_W-1:0]   writeReg,
    output logic [DATA_W-1:0]   writeData,
    output logic [NUM_REGS-1:0] pendingMask
);

    logic              full0, full1;
    logic [ADDR_W-1:0] reg0_q, reg1_q;
    logic [DATA_W-1:0] data0_q, data1_q;
    logic              last_grant;
    logic              age1_older;
    logic              grant0, grant1;
    logic              acc0, acc1;

    // last_grant=1 means req1 won last; age1_older=1 means buf1 holds the older entry
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (full0 && full1) begin
            if (reg0_q == reg1_q)
                grant0 = !age1_older;
            else
                grant0 = last_grant;
            grant1 = !grant0;
        end else begin
            grant0 = full0;
            grant1 = full1;
        end
    end

    assign req0Ready = !full0 || grant0;
    assign req1Ready = !full1 || grant1;
    assign acc0      = req0Valid && req0Ready;
    assign acc1      = req1Valid && req1Ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full0      <= 1'b0;
            full1      <= 1'b0;
            reg0_q     <= '0;
            reg1_q     <= '0;
            data0_q    <= '0;
            data1_q    <= '0;
            last_grant <= 1'b1;
            age1_older <= 1'b0;
        end else begin
            if (acc0) begin
                full0   <= 1'b1;
                reg0_q  <= req0Reg;
                data0_q <= req0Data;
            end else if (grant0) begin
                full0 <= 1'b0;
            end
            if (acc1) begin
                full1   <= 1'b1;
                reg1_q  <= req1Reg;
                data1_q <= req1Data;
            end else if (grant1) begin
                full1 <= 1'b0;
            end
            if (grant0 || grant1)
                last_grant <= grant1;
            // A fresh entry is always younger; a same-edge pair orders req0 first
            if (acc0 && !acc1)
                age1_older <= 1'b1;
            else if (acc1)
                age1_older <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            regWrite <= grant0 || grant1;
            if (grant0) begin
                writeReg  <= reg0_q;
                writeData <= data0_q;
            end else if (grant1) begin
                writeReg  <= reg1_q;
                writeData <= data1_q;
            end
        end
    end

`ifdef RFARB_PENDING_EN
    logic [NUM_REGS-1:0] pend;

    always_comb begin
        pend = '0;
        if (full0)
            pend[reg0_q] = 1'b1;
        if (full1)
            pend[reg1_q] = 1'b1;
        if (regWrite)
            pend[writeReg] = 1'b1;
    end

    assign pendingMask = pend;
`else
    assign pendingMask = '0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter; expected writes are queued at
// stimulus time and popped by a monitor whenever regWrite is seen.
module tb_rf_write_arbiter;

    typedef struct {
        logic [2:0] r;
        logic [7:0] d;
    } item_t;

    logic       clk;
    logic       rst;
    logic       req0Valid, req0Ready;
    logic [2:0] req0Reg;
    logic [7:0] req0Data;
    logic       req1Valid, req1Ready;
    logic [2:0] req1Reg;
    logic [7:0] req1Data;
    logic       regWrite;
    logic [2:0] writeReg;
    logic [7:0] writeData;
    logic [7:0] pendingMask;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    first_acc;
    int    stall0;
    item_t q0[$];
    item_t q1[$];
    item_t exp_q[$];
    item_t mon_e;
    int    stamps[$];
    bit    rdy0_log[$];
    bit    rdy1_log[$];
    logic [7:0] rf [8];
    logic [7:0] wr_seen;

`ifdef RFARB_PENDING_EN
    localparam logic [7:0] PEND7 = 8'h80;
`else
    localparam logic [7:0] PEND7 = 8'h00;
`endif

    rf_write_arbiter dut (
        .clk(clk),
        .rst(rst),
        .req0Valid(req0Valid),
        .req0Ready(req0Ready),
        .req0Reg(req0Reg),
        .req0Data(req0Data),
        .req1Valid(req1Valid),
        .req1Ready(req1Ready),
        .req1Reg(req1Reg),
        .req1Data(req1Data),
        .regWrite(regWrite),
        .writeReg(writeReg),
        .writeData(writeData),
        .pendingMask(pendingMask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && regWrite) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got reg=%0d data=%h, none queued",
                         writeReg, writeData);
            end else begin
                mon_e = exp_q.pop_front();
                if ({writeReg, writeData} !== {mon_e.r, mon_e.d}) begin
                    errors++;
                    $display("FAIL write_order: got reg=%0d data=%h, want reg=%0d data=%h",
                             writeReg, writeData, mon_e.r, mon_e.d);
                end
            end
            rf[writeReg] = writeData;
            wr_seen[writeReg] = 1'b1;
            stamps.push_back(cyc);
        end
`ifndef RFARB_PENDING_EN
        checks++;
        if (pendingMask !== 8'h00) begin
            errors++;
            $display("FAIL mask_tied: got %h, want 00", pendingMask);
        end
`endif
    end

    task automatic push(input bit side, input logic [2:0] r, input logic [7:0] d);
        item_t it;
        it.r = r;
        it.d = d;
        if (side) q1.push_back(it);
        else q0.push_back(it);
    endtask

    task automatic expect_wr(input logic [2:0] r, input logic [7:0] d);
        item_t it;
        it.r = r;
        it.d = d;
        exp_q.push_back(it);
    endtask

    task automatic drive(input int max_cyc);
        int n;
        bit f0, f1;
        n = 0;
        first_acc = -1;
        stall0 = 0;
        rdy0_log.delete();
        rdy1_log.delete();
        while ((q0.size() > 0 || q1.size() > 0) && n < max_cyc) begin
            @(negedge clk);
            req0Valid = q0.size() > 0;
            req1Valid = q1.size() > 0;
            if (req0Valid) begin
                req0Reg  = q0[0].r;
                req0Data = q0[0].d;
            end
            if (req1Valid) begin
                req1Reg  = q1[0].r;
                req1Data = q1[0].d;
            end
            rdy0_log.push_back(req0Ready);
            rdy1_log.push_back(req1Ready);
            f0 = req0Valid && req0Ready;
            f1 = req1Valid && req1Ready;
            if (req0Valid && !req0Ready) stall0++;
            @(posedge clk);
            #1;
            if ((f0 || f1) && first_acc < 0) first_acc = cyc;
            if (f0) void'(q0.pop_front());
            if (f1) void'(q1.pop_front());
            n++;
        end
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        if (n >= max_cyc) begin
            errors++;
            $display("FAIL drive_timeout: %0d items left, want 0", q0.size() + q1.size());
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d writes missing, want 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({regWrite, writeReg, writeData} !== 12'h000) begin
            errors++;
            $display("FAIL reset_out: got %b/%0d/%h, want 0/0/00", regWrite, writeReg, writeData);
        end
        checks++;
        if ({req0Ready, req1Ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready: got %b, want 11", {req0Ready, req1Ready});
        end
        checks++;
        if (pendingMask !== 8'h00) begin
            errors++;
            $display("FAIL reset_mask: got %h, want 00", pendingMask);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_streaming();
        stamps.delete();
        for (int i = 1; i <= 4; i++) begin
            push(0, 3'(i), 8'(i * 8'h11));
            expect_wr(3'(i), 8'(i * 8'h11));
        end
        drive(20);
        drain();
        checks++;
        if (stall0 != 0) begin
            errors++;
            $display("FAIL stream_ready: %0d stalls, want 0", stall0);
        end
        checks++;
        if (stamps.size() != 4 || stamps[0] != first_acc + 1) begin
            errors++;
            $display("FAIL stream_latency: first write cyc %0d, want %0d",
                     stamps.size() > 0 ? stamps[0] : -1, first_acc + 1);
        end
        checks++;
        if (stamps.size() != 4 || stamps[3] - stamps[0] != 3) begin
            errors++;
            $display("FAIL stream_b2b: %0d writes, want 4 consecutive", stamps.size());
        end
    endtask

    task automatic test_reset_mid();
        wr_seen = '0;
        @(negedge clk);
        req0Valid = 1'b1;
        req0Reg   = 3'd3;
        req0Data  = 8'h5A;
        @(posedge clk);
        #1;
        rst = 1'b1;
        req0Valid = 1'b0;
        @(negedge clk);
        checks++;
        if (regWrite !== 1'b0) begin
            errors++;
            $display("FAIL midreset_write: got %b, want 0", regWrite);
        end
        checks++;
        if ({req0Ready, req1Ready} !== 2'b11) begin
            errors++;
            $display("FAIL midreset_ready: got %b, want 11", {req0Ready, req1Ready});
        end
        checks++;
        if (pendingMask !== 8'h00) begin
            errors++;
            $display("FAIL midreset_mask: got %h, want 00", pendingMask);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (wr_seen[3] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_reg3: reg3 written with %h, want no write", rf[3]);
        end
    endtask

    task automatic test_contention();
        stamps.delete();
        for (int i = 0; i < 4; i++) begin
            push(0, 3'd2, 8'hA0 + 8'(i));
            push(1, 3'd5, 8'hB0 + 8'(i));
        end
        for (int i = 0; i < 4; i++) begin
            expect_wr(3'd2, 8'hA0 + 8'(i));
            expect_wr(3'd5, 8'hB0 + 8'(i));
        end
        drive(30);
        drain();
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (rdy0_log[i] !== i[0] || rdy1_log[i] !== !i[0]) begin
                errors++;
                $display("FAIL contend_ready[%0d]: got %b%b, want %b%b",
                         i, rdy0_log[i], rdy1_log[i], i[0], !i[0]);
            end
        end
        checks++;
        if (stamps.size() != 8 || stamps[7] - stamps[0] != 7) begin
            errors++;
            $display("FAIL contend_rate: %0d writes, want 8 consecutive", stamps.size());
        end
    endtask

    task automatic test_same_reg_tie();
        push(0, 3'd0, 8'hEE);
        expect_wr(3'd0, 8'hEE);
        drive(10);
        drain();
        push(0, 3'd6, 8'h01);
        push(1, 3'd6, 8'h02);
        expect_wr(3'd6, 8'h01);
        expect_wr(3'd6, 8'h02);
        drive(10);
        drain();
        checks++;
        if (rf[6] !== 8'h02) begin
            errors++;
            $display("FAIL tie_final: reg6 got %h, want 02", rf[6]);
        end
    endtask

    task automatic test_same_reg_age();
        push(0, 3'd1, 8'h10);
        push(0, 3'd3, 8'h30);
        push(0, 3'd4, 8'h66);
        push(1, 3'd2, 8'h20);
        push(1, 3'd4, 8'h77);
        expect_wr(3'd1, 8'h10);
        expect_wr(3'd2, 8'h20);
        expect_wr(3'd3, 8'h30);
        expect_wr(3'd4, 8'h77);
        expect_wr(3'd4, 8'h66);
        drive(20);
        drain();
        checks++;
        if (rf[4] !== 8'h66) begin
            errors++;
            $display("FAIL age_final: reg4 got %h, want 66", rf[4]);
        end
    endtask

    task automatic test_pending();
        bit f;
        @(negedge clk);
        req1Valid = 1'b1;
        req1Reg   = 3'd7;
        req1Data  = 8'hC7;
        expect_wr(3'd7, 8'hC7);
        f = req1Ready;
        @(posedge clk);
        #1;
        req1Valid = 1'b0;
        checks++;
        if (!f) begin
            errors++;
            $display("FAIL pend_accept: ready got 0, want 1");
        end
        @(negedge clk);
        checks++;
        if (pendingMask !== PEND7) begin
            errors++;
            $display("FAIL pend_buffered: got %h, want %h", pendingMask, PEND7);
        end
        @(negedge clk);
        checks++;
        if (regWrite !== 1'b1 || pendingMask !== PEND7) begin
            errors++;
            $display("FAIL pend_writing: got %b/%h, want 1/%h", regWrite, pendingMask, PEND7);
        end
        @(negedge clk);
        checks++;
        if (pendingMask !== 8'h00) begin
            errors++;
            $display("FAIL pend_clear: got %h, want 00", pendingMask);
        end
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        req0Valid = 1'b0;
        req0Reg   = '0;
        req0Data  = '0;
        req1Valid = 1'b0;
        req1Reg   = '0;
        req1Data  = '0;
        wr_seen   = '0;
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        test_reset();
        test_streaming();
        test_reset_mid();
        test_contention();
        test_same_reg_tie();
        test_same_reg_age();
        test_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
